// File: rtl/addsub_scheduler_pkg.sv
// rtl/addsub_scheduler_pkg.sv - shared encodings for the add/sub scheduler
package addsub_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/adder_subtractor_8.sv
// rtl/adder_subtractor_8.sv - 8-bit add/subtract unit with carry-in, carry-out and signed overflow
module adder_subtractor_8
  import addsub_scheduler_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       sel,
  input  logic       cin,
  output logic [7:0] result,
  output logic       cout,
  output logic       overflow
);

  logic [7:0] y_eff;

  always_comb begin
    y_eff            = (sel == OP_SUB) ? ~y : y;
    {cout, result}   = {1'b0, x} + {1'b0, y_eff} + {8'b0, cin};
    // Signed overflow: both addends share a sign that the sum does not.
    overflow         = (x[7] == y_eff[7]) && (result[7] != x[7]);
  end

endmodule

// File: rtl/addsub_scheduler.sv
// rtl/addsub_scheduler.sv - round-robin sharing of one 8-bit add/sub unit across two requesters
// Optional ADDSUB_SCHEDULER_SAT_EN: saturate the result to the signed limit on overflow.
module addsub_scheduler
  import addsub_scheduler_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NPASS = WIDTH / 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req0_op,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic             i_req1_op,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_cout,
  output logic             o_rsp_overflow,
  output logic             o_rsp_id
);

  localparam int CW = (NPASS > 1) ? $clog2(NPASS) : 1;

  state_t           state_q, state_d;
  logic             last_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             op_q, carry_q, ovf_q, id_q;
  logic [CW-1:0]    pass_q;
  logic             grant0, grant1, accept, last_pass;
  logic [7:0]       unit_x, unit_y, unit_r;
  logic             unit_cin, unit_cout, unit_ovf;

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    grant0 = i_req0_valid && (!i_req1_valid || (last_q == ID_REQ1));
    grant1 = i_req1_valid && (!i_req0_valid || (last_q == ID_REQ0));
  end

  assign o_req0_ready = !i_rst && (state_q == ST_IDLE) && grant0;
  assign o_req1_ready = !i_rst && (state_q == ST_IDLE) && grant1;
  assign accept       = o_req0_ready || o_req1_ready;
  assign last_pass    = (pass_q == CW'(NPASS - 1));

  assign unit_x   = a_q[8*pass_q +: 8];
  assign unit_y   = b_q[8*pass_q +: 8];
  assign unit_cin = (pass_q == '0) ? op_q : carry_q;

  adder_subtractor_8 u_unit (
    .x        (unit_x),
    .y        (unit_y),
    .sel      (op_q),
    .cin      (unit_cin),
    .result   (unit_r),
    .cout     (unit_cout),
    .overflow (unit_ovf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: if (last_pass) state_d = ST_DONE;
      ST_DONE: if (i_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      last_q  <= ID_REQ1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      id_q    <= ID_REQ0;
      pass_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q    <= o_req1_ready ? i_req1_a : i_req0_a;
            b_q    <= o_req1_ready ? i_req1_b : i_req0_b;
            op_q   <= o_req1_ready ? i_req1_op : i_req0_op;
            id_q   <= o_req1_ready;
            last_q <= o_req1_ready;
            pass_q <= '0;
          end
        end
        ST_CALC: begin
          res_q[8*pass_q +: 8] <= unit_r;
          carry_q              <= unit_cout;
          pass_q               <= pass_q + CW'(1);
          if (last_pass) begin
            ovf_q <= unit_ovf;
`ifdef ADDSUB_SCHEDULER_SAT_EN
            // A positive A can only overflow upward, a negative A only downward.
            if (unit_ovf)
              res_q <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid    = (state_q == ST_DONE);
  assign o_rsp_result   = res_q;
  assign o_rsp_cout     = carry_q;
  assign o_rsp_overflow = ovf_q;
  assign o_rsp_id       = id_q;

endmodule

// File: tb/tb_addsub_scheduler.sv
// tb/tb_addsub_scheduler.sv - scoreboard bench for addsub_scheduler (WIDTH=16)
module tb_addsub_scheduler;
  import addsub_scheduler_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   vld = 2'b00;
  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];
  logic [1:0]   rop = 2'b00;
  logic         rsp_rdy = 1'b1;
  logic         rdy0, rdy1, rsp_valid, rsp_cout, rsp_ovf, rsp_id;
  logic [W-1:0] rsp_res;
  logic [1:0]   rdy_v;

  always #5 clk = ~clk;
  assign rdy_v = {rdy1, rdy0};

  addsub_scheduler #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req0_valid   (vld[0]),
    .o_req0_ready   (rdy0),
    .i_req0_a       (ra[0]),
    .i_req0_b       (rb[0]),
    .i_req0_op      (rop[0]),
    .i_req1_valid   (vld[1]),
    .o_req1_ready   (rdy1),
    .i_req1_a       (ra[1]),
    .i_req1_b       (rb[1]),
    .i_req1_op      (rop[1]),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_rdy),
    .o_rsp_result   (rsp_res),
    .o_rsp_cout     (rsp_cout),
    .o_rsp_overflow (rsp_ovf),
    .o_rsp_id       (rsp_id)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         id;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];
  int   order[$];
  logic tb_last = 1'b1;
  bit   rand_done = 1'b0;
  rsp_t mon_act, mon_exp;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce to the WIDTH-bit view.
  function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic op, input logic rid);
    longint ua, ub, sa, sbv, s, full, lim;
    rsp_t   e;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (op == OP_SUB) begin
      full = ua - ub;
      e.c  = (ua >= ub);
      s    = sa - sbv;
    end else begin
      full = ua + ub;
      e.c  = (full >= (longint'(1) << W));
      s    = sa + sbv;
    end
    e.r  = full[W-1:0];
    e.v  = (s > lim - 1) || (s < -lim);
`ifdef ADDSUB_SCHEDULER_SAT_EN
    if (e.v) e.r = (s > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    e.id = rid;
    return e;
  endfunction

  // Handshake observer: arbitration check and scoreboard push.
  always @(negedge clk) begin
    if (rst) begin
      tb_last = 1'b1;
    end else begin
      if (rdy0 || rdy1) chk(!(rdy0 && rdy1), "single_ready", rdy_v, 1);
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && rdy_v[i]) begin
          if (vld == 2'b11) chk(i == int'(!tb_last), "rr_grant", i, int'(!tb_last));
          sb.push_back(model(ra[i], rb[i], rop[i], i[0]));
          order.push_back(i);
          tb_last = i[0];
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_rdy) begin
      mon_act = {rsp_res, rsp_cout, rsp_ovf, rsp_id};
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_rsp", mon_act, 0);
      end else begin
        mon_exp = sb.pop_front();
        chk(mon_act == mon_exp, "rsp{res,cout,ovf,id}", mon_act, mon_exp);
      end
    end
  end

  task automatic issue(input int rid, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op, output int wait_n);
    @(posedge clk); #1;
    ra[rid]  = a;
    rb[rid]  = b;
    rop[rid] = op;
    vld[rid] = 1'b1;
    wait_n   = 0;
    forever begin
      @(negedge clk);
      if (rdy_v[rid]) break;
      wait_n++;
      if (wait_n > 300) begin
        chk(1'b0, "grant_timeout", rid, 0);
        break;
      end
    end
    @(posedge clk); #1;
    vld[rid] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, name, sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(rsp_valid == 1'b0, {name, "_valid"}, rsp_valid, 0);
    chk({rsp_res, rsp_cout, rsp_ovf, rsp_id} == '0, {name, "_rsp"},
        {rsp_res, rsp_cout, rsp_ovf, rsp_id}, 0);
    chk(rdy_v == 2'b00, {name, "_ready"}, rdy_v, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int   n0, n1, nv;
    logic [3:0] ov;
    ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;

    // Reset state with both requesters asking.
    vld = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    vld = 2'b00;
    rst = 1'b0;

    // Both valid from reset: two 0x7FFF+1 each, grants must alternate 0,1,0,1.
    fork
      begin issue(0, 16'h7FFF, 16'h0001, OP_ADD, n0); issue(0, 16'h7FFF, 16'h0001, OP_ADD, n0); end
      begin issue(1, 16'h7FFF, 16'h0001, OP_ADD, n1); issue(1, 16'h7FFF, 16'h0001, OP_ADD, n1); end
    join
    drain("drain_rr");
    ov = '1;
    if (order.size() >= 4) ov = {order[0][0], order[1][0], order[2][0], order[3][0]};
    chk(order.size() == 4 && ov == 4'b0101, "grant_order", ov, 4'b0101);

    // Req0 add with carry across bytes, latency to valid.
    issue(0, 16'h00FF, 16'h0001, OP_ADD, n0);
    chk(n0 == 0, "req0_ready_cycle0", n0, 0);
    @(negedge clk); chk(rsp_valid == 1'b0, "lat_cycle1", rsp_valid, 0);
    @(negedge clk); chk(rsp_valid == 1'b0, "lat_cycle2", rsp_valid, 0);
    @(negedge clk); chk(rsp_valid == 1'b1, "lat_cycle3", rsp_valid, 1);
    drain("drain_t1");

    // Req1 subtract with borrow.
    issue(1, 16'h0000, 16'h0001, OP_SUB, n1);
    drain("drain_t2");

    // Response stall: outputs held, no ready while a second requester waits.
    rsp_rdy = 1'b0;
    issue(0, 16'hFFFF, 16'hFFFF, OP_ADD, n0);
    fork
      issue(1, 16'h0003, 16'h0001, OP_SUB, n1);
    join_none
    nv = 0;
    while (!rsp_valid && nv < 20) begin @(negedge clk); nv++; end
    chk(rsp_valid == 1'b1, "stall_valid_seen", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk({rsp_valid, rsp_res, rsp_cout} == {1'b1, 16'hFFFE, 1'b1}, "stall_hold",
          {rsp_valid, rsp_res, rsp_cout}, {1'b1, 16'hFFFE, 1'b1});
      chk(rdy_v == 2'b00, "stall_no_ready", rdy_v, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    wait fork;
    drain("drain_stall");

    // Reset during CALC pass 1 discards the operation.
    issue(0, 16'h1234, 16'h0234, OP_SUB, n0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("abort");
    rst = 1'b0;
    sb.delete();
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    chk(nv == 0, "abort_no_rsp", nv, 0);
    issue(0, 16'h1234, 16'h0234, OP_SUB, n0);
    drain("drain_abort");

    // Negative-to-positive signed overflow on subtract.
    issue(0, 16'h8000, 16'h0001, OP_SUB, n0);
    drain("drain_ovf_sub");

    // Random traffic with random consumer backpressure.
    fork
      begin
        fork
          for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(0, W'($urandom), W'($urandom), 1'($urandom), n0);
          end
          for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(1, W'($urandom), W'($urandom), 1'($urandom), n1);
          end
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        rsp_rdy = ($urandom_range(0, 3) != 0);
      end
    join
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
